// File: rtl/program_loader.sv
// Streams RAM_DEPTH program words into RAM while holding the CPU, then pulses o_done.
// Optional checksum byte verification is built in when LOADER_CHECKSUM_EN is defined.
module program_loader #(
   parameter int RAM_DEPTH = 16,
   parameter int RAM_WIDTH = 8
) (
   input  logic                         mclk,
   input  logic                         rst,
   input  logic                         mclk_en,
   input  logic                         i_start,
   input  logic                         i_data_valid,
   input  logic [RAM_WIDTH-1:0]         i_data,
   output logic                         o_data_ready,
   output logic                         o_ram_load_enable,
   output logic [$clog2(RAM_DEPTH)-1:0] o_ram_address,
   output logic [RAM_WIDTH-1:0]         o_ram_load_data,
   output logic                         o_cpu_hold,
   output logic                         o_done,
   output logic                         o_error
);

   localparam int ADDRESS_WIDTH = $clog2(RAM_DEPTH);
   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDRESS = ADDRESS_WIDTH'(RAM_DEPTH - 1);

`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHECK, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE} state_t;
`endif

   state_t                   state;
   state_t                   state_nxt;
   logic [ADDRESS_WIDTH-1:0] addr_cnt;
   logic                     last_word;

   assign last_word = (o_ram_address == LAST_ADDRESS);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; reset is asynchronous and ignores mclk_en.
   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         addr_cnt        <= '0;
         o_ram_address   <= '0;
         o_ram_load_data <= '0;
      end else if (mclk_en) begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (i_start) addr_cnt <= '0;
            end
            LOAD: begin
               if (i_data_valid) begin
                  o_ram_load_data <= i_data;
                  o_ram_address   <= addr_cnt;
               end
            end
            WRITE: begin
               // Counter parks on the last address so it never wraps mid-session.
               if (!last_word) addr_cnt <= addr_cnt + ADDRESS_WIDTH'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef LOADER_CHECKSUM_EN
   logic [RAM_WIDTH-1:0] sum;

   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         sum     <= '0;
         o_error <= 1'b0;
      end else if (mclk_en) begin
         case (state)
            IDLE: begin
               if (i_start) begin
                  sum     <= '0;
                  o_error <= 1'b0;
               end
            end
            WRITE:   sum <= sum + o_ram_load_data;
            CHECK: begin
               if (i_data_valid && (i_data != sum)) o_error <= 1'b1;
            end
            default: ;
         endcase
      end
   end
`else
   assign o_error = 1'b0;
`endif

   // NOTE: every output and state_nxt gets a default first so no latch is inferred.
   always_comb begin
      state_nxt         = state;
      o_data_ready      = 1'b0;
      o_ram_load_enable = 1'b0;
      o_cpu_hold        = 1'b0;
      o_done            = 1'b0;
      case (state)
         IDLE: begin
            if (i_start) state_nxt = LOAD;
         end
         LOAD: begin
            o_data_ready = 1'b1;
            o_cpu_hold   = 1'b1;
            if (i_data_valid) state_nxt = WRITE;
         end
         WRITE: begin
            o_ram_load_enable = 1'b1;
            o_cpu_hold        = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            state_nxt = last_word ? CHECK : LOAD;
`else
            state_nxt = last_word ? DONE : LOAD;
`endif
         end
`ifdef LOADER_CHECKSUM_EN
         CHECK: begin
            o_data_ready = 1'b1;
            o_cpu_hold   = 1'b1;
            if (i_data_valid) state_nxt = DONE;
         end
`endif
         DONE: begin
            o_done     = 1'b1;
            o_cpu_hold = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: a queue-based model of the expected RAM image,
// done pulse, hold window and checksum verdict is compared against observed behaviour.
module tb_program_loader;

   localparam int DEPTH = 16;
   localparam int W     = 8;
   localparam int AW    = 4;

   logic          mclk = 1'b0;
   logic          rst;
   logic          mclk_en;
   logic          i_start;
   logic          i_data_valid;
   logic [W-1:0]  i_data;
   logic          o_data_ready;
   logic          o_ram_load_enable;
   logic [AW-1:0] o_ram_address;
   logic [W-1:0]  o_ram_load_data;
   logic          o_cpu_hold;
   logic          o_done;
   logic          o_error;
   logic [16:0]   outs;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] stim[$];
   int           obs_addr[$];
   int           obs_data[$];

   program_loader #(.RAM_DEPTH(DEPTH), .RAM_WIDTH(W)) dut (
      .mclk              (mclk),
      .rst               (rst),
      .mclk_en           (mclk_en),
      .i_start           (i_start),
      .i_data_valid      (i_data_valid),
      .i_data            (i_data),
      .o_data_ready      (o_data_ready),
      .o_ram_load_enable (o_ram_load_enable),
      .o_ram_address     (o_ram_address),
      .o_ram_load_data   (o_ram_load_data),
      .o_cpu_hold        (o_cpu_hold),
      .o_done            (o_done),
      .o_error           (o_error)
   );

   always #5 mclk = ~mclk;

   assign outs = {o_data_ready, o_ram_load_enable, o_ram_address, o_ram_load_data,
                  o_cpu_hold, o_done, o_error};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Called at posedge+#1 with the loader idle; stim holds the program bytes.
   task automatic run_session(input string name, input bit en_rand, input bit valid_rand,
                              input bit start_noise, input int abort_after,
                              input logic [W-1:0] cs_byte);
      logic [W-1:0] stream[$];
      logic [W-1:0] exp_sum;
      bit           exp_err;
      bit           finished = 1'b0;
      bit           aborted  = 1'b0;
      bit           last_en_strobe = 1'b0;
      int           idx = 0;
      int           cyc = 0;
      int           done_cnt = 0;
      int           hold_gaps = 0;
      int           dbl = 0;
      int           exp_writes;

      stream = stim;
`ifdef LOADER_CHECKSUM_EN
      stream.push_back(cs_byte);
`endif
      obs_addr.delete();
      obs_data.delete();

      mclk_en      = 1'b1;
      i_start      = 1'b1;
      i_data_valid = 1'b0;
      @(posedge mclk); #1;
      i_start = 1'b0;
      check({name, "_err_cleared"}, 32'(o_error), 32'd0);

      while (!finished && !aborted && cyc < 2000) begin
         cyc++;
         mclk_en      = en_rand ? ($urandom_range(2) == 0) : 1'b1;
         i_data_valid = (idx < stream.size()) && (valid_rand ? ($urandom_range(1) == 1) : 1'b1);
         i_data       = (idx < stream.size()) ? stream[idx] : W'($urandom);
         i_start      = start_noise && ($urandom_range(3) == 0);
         @(negedge mclk);
         if (!o_cpu_hold) hold_gaps++;
         if (mclk_en) begin
            if (i_data_valid && o_data_ready) idx++;
            if (o_ram_load_enable) begin
               obs_addr.push_back(int'(o_ram_address));
               obs_data.push_back(int'(o_ram_load_data));
               if (last_en_strobe) dbl++;
            end
            if (o_done) begin
               done_cnt++;
               finished = 1'b1;
            end
            last_en_strobe = o_ram_load_enable;
         end
         @(posedge mclk); #1;
         if (abort_after > 0 && obs_addr.size() == abort_after) begin
            rst = 1'b1;
            #1;
            check({name, "_rst_outputs"}, 32'(outs), 32'd0);
            aborted = 1'b1;
         end
      end
      i_start      = 1'b0;
      i_data_valid = 1'b0;
      mclk_en      = 1'b1;

      exp_writes = aborted ? abort_after : DEPTH;
      check({name, "_ended"}, 32'(finished | aborted), 32'd1);
      check({name, "_write_count"}, 32'(obs_addr.size()), 32'(exp_writes));
      for (int i = 0; i < exp_writes && i < obs_addr.size(); i++) begin
         check($sformatf("%s_addr%0d", name, i), 32'(obs_addr[i]), 32'(i));
         check($sformatf("%s_data%0d", name, i), 32'(obs_data[i]), 32'(stim[i]));
      end
      check({name, "_hold_gaps"}, 32'(hold_gaps), 32'd0);
      check({name, "_strobe_one_cycle"}, 32'(dbl), 32'd0);

      if (aborted) begin
         @(posedge mclk); #1;
         rst = 1'b0;
         @(negedge mclk);
         check({name, "_after_rst"}, 32'(outs), 32'd0);
         @(posedge mclk); #1;
         return;
      end

      check({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
      exp_sum = '0;
      foreach (stim[i]) exp_sum = exp_sum + stim[i];
`ifdef LOADER_CHECKSUM_EN
      exp_err = (exp_sum != cs_byte);
`else
      exp_err = 1'b0;
`endif
      @(negedge mclk);
      check({name, "_hold_released"}, 32'(o_cpu_hold), 32'd0);
      check({name, "_idle_ready"}, 32'(o_data_ready), 32'd0);
      check({name, "_done_dropped"}, 32'(o_done), 32'd0);
      check({name, "_error"}, 32'(o_error), 32'(exp_err));
      repeat (3) @(negedge mclk);
      check({name, "_error_sticky"}, 32'(o_error), 32'(exp_err));
      @(posedge mclk); #1;
   endtask

   task automatic fill_ramp();
      stim.delete();
      for (int i = 0; i < DEPTH; i++) stim.push_back(W'(i));
   endtask

   task automatic fill_const(input logic [W-1:0] v);
      stim.delete();
      for (int i = 0; i < DEPTH; i++) stim.push_back(v);
   endtask

   task automatic fill_random();
      stim.delete();
      for (int i = 0; i < DEPTH; i++) stim.push_back(W'($urandom));
   endtask

   initial begin
      logic [W-1:0] s;
      rst          = 1'b1;
      mclk_en      = 1'b0;
      i_start      = 1'b0;
      i_data_valid = 1'b0;
      i_data       = '0;
      #1;
      check("reset_outputs", 32'(outs), 32'd0);
      repeat (3) @(posedge mclk);
      #1;
      rst     = 1'b0;
      mclk_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge mclk);
         check($sformatf("idle_outputs%0d", i), 32'(outs), 32'd0);
      end
      @(posedge mclk); #1;

      fill_ramp();
      run_session("ramp", 1'b0, 1'b0, 1'b0, 0, 8'h78);
      fill_const(8'h01);
      run_session("cs_good", 1'b0, 1'b0, 1'b0, 0, 8'h10);
      fill_const(8'h01);
      run_session("cs_bad", 1'b0, 1'b0, 1'b0, 0, 8'h11);
      fill_ramp();
      run_session("stall", 1'b1, 1'b1, 1'b0, 0, 8'h78);
      fill_ramp();
      run_session("abort", 1'b0, 1'b0, 1'b0, 7, 8'h00);
      fill_ramp();
      run_session("restart", 1'b0, 1'b0, 1'b0, 0, 8'h78);
      fill_ramp();
      run_session("start_noise", 1'b0, 1'b1, 1'b1, 0, 8'h78);
      for (int k = 0; k < 4; k++) begin
         fill_random();
         s = '0;
         foreach (stim[i]) s = s + stim[i];
         if ($urandom_range(1) == 1) s = s ^ W'($urandom_range(255, 1));
         run_session($sformatf("rand%0d", k), k[0], 1'b1, k[1], 0, s);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter RAM_DEPTH, default 16, number of RAM words loaded per session.
REQ-002 SHALL have parameter RAM_WIDTH, default 8, bits per RAM word and per input byte.
REQ-003 SHALL derive localparam ADDRESS_WIDTH = $clog2(RAM_DEPTH).
REQ-004 SHALL have port mclk  input  1  system clock; single clock domain.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port mclk_en  input  1  clock enable; state advances only on mclk edges with mclk_en=1.
REQ-007 SHALL have port i_start  input  1  begin a load session.
REQ-008 SHALL have port i_data_valid  input  1  source offers i_data.
REQ-009 SHALL have port i_data  input  RAM_WIDTH  program byte.
REQ-010 SHALL have port o_data_ready  output  1  loader accepts i_data.
REQ-011 SHALL have port o_ram_load_enable  output  1  RAM write strobe.
REQ-012 SHALL have port o_ram_address  output  ADDRESS_WIDTH  RAM write address.
REQ-013 SHALL have port o_ram_load_data  output  RAM_WIDTH  RAM write data.
REQ-014 SHALL have port o_cpu_hold  output  1  freezes CPU and gives the loader the RAM write port.
REQ-015 SHALL have port o_done  output  1  one-enabled-cycle completion pulse.
REQ-016 SHALL have port o_error  output  1  checksum mismatch flag, sticky.

Function
REQ-017 SHALL implement states IDLE, LOAD, WRITE, CHECK, DONE; a transfer is i_data_valid & o_data_ready & mclk_en.
REQ-018 IDLE: o_cpu_hold=0, o_data_ready=0; i_start=1 -> LOAD, address counter cleared to 0, o_error cleared.
REQ-019 LOAD: o_cpu_hold=1, o_data_ready=1; on transfer, register i_data into o_ram_load_data, counter into o_ram_address, go to WRITE.
REQ-020 WRITE: o_ram_load_enable=1, o_data_ready=0 for exactly one enabled cycle; byte added to running sum mod 2^RAM_WIDTH; counter increments.
REQ-021 After WRITE: if the written address was RAM_DEPTH-1 -> CHECK (or DONE per REQ-029), else -> LOAD; counter never wraps within a session.
REQ-022 Throughput: one byte per two enabled cycles minimum; i_data_valid low stalls LOAD indefinitely without timeout.
REQ-023 CHECK: o_data_ready=1; transfer compares byte with running sum; mismatch sets o_error; -> DONE; no RAM write.
REQ-024 DONE: o_done=1 and o_cpu_hold=1 for one enabled cycle, then IDLE.
REQ-025 i_start outside IDLE SHALL be ignored; i_data_valid in IDLE/WRITE/DONE SHALL be ignored (ready=0).
REQ-026 o_ram_load_enable SHALL be 0 in every state except WRITE.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, counter=0, sum=0, all outputs 0, regardless of mclk_en.
REQ-028 Reset mid-session SHALL release o_cpu_hold at once; already-written RAM words are left as written.

Configuration
REQ-029 Macro LOADER_CHECKSUM_EN: defined -> CHECK state present per REQ-023; undefined -> CHECK, running sum and comparison removed, LOAD after last WRITE goes directly to DONE, o_error tied 0.

Verification
REQ-030 Reset, then 5 enabled cycles idle -> all outputs 0, o_data_ready=0.
REQ-031 i_start, bytes 0x00..0x0F valid continuously -> 16 write strobes, addresses 0..15, data 0x00..0x0F, o_cpu_hold high throughout, one o_done pulse, hold drops after.
REQ-032 LOADER_CHECKSUM_EN, bytes 0x01 x16 then 0x10 -> o_error=0; repeat with 0x11 -> o_error=1 until next i_start.
REQ-033 Toggle mclk_en 1-in-3 and i_data_valid randomly during a load -> identical RAM writes to REQ-031, each strobe held exactly one enabled cycle.
REQ-034 Assert rst after 7th write -> o_cpu_hold and all outputs 0 same cycle; next i_start restarts at address 0.
REQ-035 i_start pulsed during LOAD -> no effect; session completes normally.
